cdiv_seq: RTL and testbench
===========================

CDIV_SEQ -- requirements
Module: cdiv_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The port clk SHALL be a 1-bit input: the rising-edge clock.
REQ-003 The port rst_n SHALL be a 1-bit input: asynchronous, active-low reset.
REQ-004 The port a SHALL be an 8-bit input: the dividend, packed as {im[3:0], re[3:0]}, each field 4-bit two's complement.
REQ-005 The port b SHALL be an 8-bit input: the divisor, packed the same way as a.
REQ-006 The port start SHALL be a 1-bit input: request; a and b are sampled on the edge that accepts start.
REQ-007 The port busy SHALL be a 1-bit output: high from the accept edge until done deasserts.
REQ-008 The port done SHALL be a 1-bit output: a one-cycle pulse marking that the results are valid.
REQ-009 The port result_re SHALL be an 8-bit output: the real part of the quotient, signed Q4.4.
REQ-010 The port result_im SHALL be an 8-bit output: the imaginary part of the quotient, signed Q4.4.
REQ-011 The port dz SHALL be a 1-bit output: divide-by-zero flag, valid with done.
REQ-012 The port ovf SHALL be a 1-bit output: saturation flag, valid with done; set if either part saturated.

Function
REQ-013 The block SHALL compute a/b = ((ar*br + ai*bi) + j(ai*br - ar*bi)) / (br^2 + bi^2).
REQ-014 The numerators SHALL be 9-bit signed, the denominator 8-bit unsigned (max 128), and all products exact.
REQ-015 Each part SHALL be computed as q = (|num| << 4) / den: 12-bit unsigned, truncated toward zero, with the sign of num then applied.
REQ-016 A signed q above 127 SHALL saturate to 0x7F, and a q below -128 SHALL saturate to 0x80; either case SHALL set ovf.
REQ-017 The FSM states SHALL be IDLE, PREP, DIV_RE, DIV_IM and DONE.
REQ-018 In IDLE, start=1 SHALL latch a and b, set busy and go to PREP; start=0 SHALL leave the block in IDLE.
REQ-019 PREP SHALL take one cycle to compute num_re, num_im and den: if den=0, go to DONE with dz=1 and results 0x00; otherwise go to DIV_RE.
REQ-020 DIV_RE and DIV_IM SHALL each perform 12 restoring-division iterations, one per cycle; DIV_IM SHALL follow DIV_RE.
REQ-021 The final DIV_IM iteration SHALL register the results and the flags and go to DONE.
REQ-022 DONE SHALL last one cycle with done=1 and SHALL return to IDLE; busy SHALL drop with done.
REQ-023 Latency: counting the accept edge as edge 1, done SHALL be high after edge 26 when den≠0, and after edge 2 when den=0.
REQ-024 start while busy SHALL be ignored without queuing; start in the DONE cycle SHALL also be ignored.
REQ-025 result_re, result_im, dz and ovf SHALL hold their values until the next done.
REQ-026 Changes on a and b after the accept edge SHALL have no effect on the current operation.

Reset
REQ-027 rst_n=0 SHALL, at any time including mid-division, force state=IDLE, busy=0, done=0, result_re=0x00, result_im=0x00, dz=0, ovf=0 and clear the iteration counter.
REQ-028 After release, the first accepted start SHALL behave exactly as from power-up.

Structure
REQ-029 A shared package cdiv_pkg SHALL hold the state enum, the widths (part 4, num 9, den 8, quotient 12) and the constants DIV_ITERS=12 and LATENCY=26.
REQ-030 One sub-module, udiv12_seq, SHALL be the 12-bit-by-8-bit restoring divider (load, step, quotient, remainder), time-shared between the real and imaginary parts.

Verification
REQ-031 The bench SHALL cover: a=0x02, b=0x01 -> result_re=0x20, result_im=0x00, dz=0, ovf=0, done after edge 26.
REQ-032 The bench SHALL cover: a=0x11, b=0x11 -> result_re=0x10, result_im=0x00.
REQ-033 The bench SHALL cover: a=0x01, b=0x10 -> result_re=0x00, result_im=0xF0 (-1.0).
REQ-034 The bench SHALL cover: a=0x08, b=0x0F -> result_re=0x7F, ovf=1, result_im=0x00.
REQ-035 The bench SHALL cover: a=0x35, b=0x00 -> dz=1, results 0x00, done after edge 2; a start during that busy window -> ignored.
REQ-036 The bench SHALL cover: rst_n pulsed low during DIV_IM -> all outputs zero immediately; the next start with a=0x02, b=0x01 -> 0x20/0x00 with full latency.

Source files
------------

// File: rtl/cdiv_pkg.sv
// Shared definitions for the sequential complex divider.
// Holds the controller state encoding, the datapath widths and the
// iteration/latency constants used by cdiv_seq and udiv12_seq.
package cdiv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        DIV_RE,
        DIV_IM,
        DONE
    } state_t;

    localparam int PART_W    = 4;   // each re/im field of an operand
    localparam int NUM_W     = 9;   // signed numerator width
    localparam int DEN_W     = 8;   // unsigned denominator width
    localparam int QUO_W     = 12;  // raw unsigned quotient width
    localparam int OUT_W     = 8;   // signed Q4.4 result width
    localparam int CNT_W     = 4;   // iteration counter width
    localparam int DIV_ITERS = 12;  // restoring iterations per part
    localparam int LATENCY   = 26;  // accept edge to done edge, den != 0

endpackage

// File: rtl/cdiv_seq_if.sv
// Request/result bundle of the complex divider.
//   a, b, start          : operands and request (master -> slave)
//   busy, done           : status, done is a one-cycle pulse
//   result_re, result_im : signed Q4.4 quotient parts
//   dz, ovf              : divide-by-zero and saturation flags
interface cdiv_seq_if;

    logic [7:0] a;
    logic [7:0] b;
    logic       start;
    logic       busy;
    logic       done;
    logic [7:0] result_re;
    logic [7:0] result_im;
    logic       dz;
    logic       ovf;

    modport master (
        output a, b, start,
        input  busy, done, result_re, result_im, dz, ovf
    );

    modport slave (
        input  a, b, start,
        output busy, done, result_re, result_im, dz, ovf
    );

endinterface

// File: rtl/udiv12_seq.sv
// 12-bit by 8-bit unsigned restoring divider, one quotient bit per step.
//   clk       : rising-edge clock
//   load      : capture dividend, clear partial remainder (wins over step)
//   step      : perform one restoring iteration
//   dividend  : 12-bit dividend
//   divisor   : 8-bit divisor, held stable while stepping
//   quotient  : quotient register (valid after 12 steps)
//   remainder : partial remainder register
//   quo_next  : quotient value that the current step will produce
module udiv12_seq
    import cdiv_pkg::*;
(
    input  logic             clk,
    input  logic             load,
    input  logic             step,
    input  logic [QUO_W-1:0] dividend,
    input  logic [DEN_W-1:0] divisor,
    output logic [QUO_W-1:0] quotient,
    output logic [DEN_W-1:0] remainder,
    output logic [QUO_W-1:0] quo_next
);

    // The quotient register doubles as the dividend shifter: dividend bits
    // leave at the top while quotient bits enter at the bottom.
    logic [DEN_W:0]   trial;
    logic [DEN_W:0]   diff;
    logic             fits;
    logic [DEN_W-1:0] rem_next;

    assign trial    = {remainder, quotient[QUO_W-1]};
    assign diff     = trial - {1'b0, divisor};
    assign fits     = (trial >= {1'b0, divisor});
    // Remainder stays below divisor (<= 128), so 8 bits always suffice.
    assign rem_next = fits ? diff[DEN_W-1:0] : trial[DEN_W-1:0];
    assign quo_next = {quotient[QUO_W-2:0], fits};

    always_ff @(posedge clk) begin
        if (load) begin
            quotient  <= dividend;
            remainder <= '0;
        end else if (step) begin
            quotient  <= quo_next;
            remainder <= rem_next;
        end
    end

endmodule

// File: rtl/cdiv_seq.sv
// Sequential complex divider: a/b for 4-bit two's complement re/im parts,
// producing signed Q4.4 results with saturation and divide-by-zero flag.
// One shared restoring divider computes the real part, then the imaginary.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : request/result bundle (slave side)
module cdiv_seq
    import cdiv_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    cdiv_seq_if.slave bus
);

    state_t                   state;
    logic [CNT_W-1:0]         cnt;
    logic [7:0]               a_q, b_q;
    logic [QUO_W-1:0]         q_re_keep;

    logic                     busy_r, done_r, dz_r, ovf_r;
    logic [OUT_W-1:0]         res_re_r, res_im_r;

    logic signed [PART_W-1:0] ar, ai, br, bi;
    logic signed [NUM_W-1:0]  ar_x, ai_x, br_x, bi_x;
    logic signed [NUM_W-1:0]  num_re, num_im, den_full;
    logic [DEN_W-1:0]         den;
    logic [NUM_W-1:0]         mag_re, mag_im;
    logic [QUO_W-1:0]         dvd_re, dvd_im;

    logic                     last;
    logic                     div_load, div_step;
    logic [QUO_W-1:0]         div_dvd, div_quo, div_quo_next;
    logic [DEN_W-1:0]         div_rem;
    logic [OUT_W:0]           sat_re, sat_im;
    logic                     unused_bits;

    // Returns {saturated, value}: applies the sign to the magnitude quotient
    // and clamps to the signed 8-bit range.
    function automatic logic [OUT_W:0] sat_q(input logic neg, input logic [QUO_W-1:0] q);
        logic [OUT_W-1:0] neg_q;
        neg_q = ~q[OUT_W-1:0] + 8'd1;
        if (!neg)
            return (q > QUO_W'(127)) ? {1'b1, 8'h7F} : {1'b0, q[OUT_W-1:0]};
        else
            return (q > QUO_W'(128)) ? {1'b1, 8'h80} : {1'b0, neg_q};
    endfunction

    // Operand unpacking and exact products
    assign ar = a_q[3:0];
    assign ai = a_q[7:4];
    assign br = b_q[3:0];
    assign bi = b_q[7:4];

    assign ar_x = NUM_W'(ar);
    assign ai_x = NUM_W'(ai);
    assign br_x = NUM_W'(br);
    assign bi_x = NUM_W'(bi);

    assign num_re   = ar_x * br_x + ai_x * bi_x;
    assign num_im   = ai_x * br_x - ar_x * bi_x;
    assign den_full = br_x * br_x + bi_x * bi_x;
    assign den      = den_full[DEN_W-1:0];

    // |num| never exceeds 128, so its low 8 bits carry the whole magnitude.
    assign mag_re = num_re[NUM_W-1] ? NUM_W'(-num_re) : NUM_W'(num_re);
    assign mag_im = num_im[NUM_W-1] ? NUM_W'(-num_im) : NUM_W'(num_im);
    assign dvd_re = {mag_re[7:0], 4'b0000};
    assign dvd_im = {mag_im[7:0], 4'b0000};

    // Divider sequencing: the last real step hands over straight to loading
    // the imaginary dividend, so the real quotient is taken from quo_next.
    assign last     = (cnt == CNT_W'(DIV_ITERS - 1));
    assign div_load = (state == PREP) || ((state == DIV_RE) && last);
    assign div_step = (state == DIV_RE) || (state == DIV_IM);
    assign div_dvd  = (state == PREP) ? dvd_re : dvd_im;

    udiv12_seq u_div (
        .clk       (clk),
        .load      (div_load),
        .step      (div_step),
        .dividend  (div_dvd),
        .divisor   (den),
        .quotient  (div_quo),
        .remainder (div_rem),
        .quo_next  (div_quo_next)
    );

    assign sat_re = sat_q(num_re[NUM_W-1], q_re_keep);
    assign sat_im = sat_q(num_im[NUM_W-1], div_quo_next);

    assign unused_bits = ^{den_full[NUM_W-1], mag_re[NUM_W-1], mag_im[NUM_W-1], div_quo, div_rem};

    // Operand capture and real-part hold
    always_ff @(posedge clk) begin
        if ((state == IDLE) && bus.start) begin
            a_q <= bus.a;
            b_q <= bus.b;
        end
        if ((state == DIV_RE) && last)
            q_re_keep <= div_quo_next;
    end

    // Controller
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            dz_r     <= 1'b0;
            ovf_r    <= 1'b0;
            res_re_r <= '0;
            res_im_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        busy_r <= 1'b1;
                        state  <= PREP;
                    end
                end
                PREP: begin
                    cnt <= '0;
                    if (den == '0) begin
                        dz_r     <= 1'b1;
                        ovf_r    <= 1'b0;
                        res_re_r <= '0;
                        res_im_r <= '0;
                        done_r   <= 1'b1;
                        state    <= DONE;
                    end else begin
                        state <= DIV_RE;
                    end
                end
                DIV_RE: begin
                    if (last) begin
                        cnt   <= '0;
                        state <= DIV_IM;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DIV_IM: begin
                    if (last) begin
                        cnt      <= '0;
                        res_re_r <= sat_re[OUT_W-1:0];
                        res_im_r <= sat_im[OUT_W-1:0];
                        ovf_r    <= sat_re[OUT_W] | sat_im[OUT_W];
                        dz_r     <= 1'b0;
                        done_r   <= 1'b1;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.dz        = dz_r;
    assign bus.ovf       = ovf_r;
    assign bus.result_re = res_re_r;
    assign bus.result_im = res_im_r;

endmodule

// File: tb/tb_cdiv_seq.sv
// Directed bench for cdiv_seq with hand-computed quotients and latencies.
module tb_cdiv_seq;
    import cdiv_pkg::*;

    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;

    cdiv_seq_if ifc ();

    cdiv_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    // Issues one request, scrambles the operands after acceptance, counts
    // edges to done and checks results, flags and the return to idle.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v,
                          input logic [7:0] er, input logic [7:0] ei,
                          input logic edz, input logic eovf,
                          input int elat, input string tag);
        int n;
        bit seen;
        @(negedge clk);
        ifc.a     = ta;
        ifc.b     = tb_v;
        ifc.start = 1'b1;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        ifc.a     = ~ta;
        ifc.b     = ~tb_v;
        chk({tag, "_busy"}, {7'd0, ifc.busy}, 8'd1);
        n    = 1;
        seen = 1'b0;
        while (!seen && n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (ifc.done) seen = 1'b1;
        end
        chk({tag, "_lat"}, 8'(n), 8'(elat));
        chk({tag, "_re"}, ifc.result_re, er);
        chk({tag, "_im"}, ifc.result_im, ei);
        chk({tag, "_dz"}, {7'd0, ifc.dz}, {7'd0, edz});
        chk({tag, "_ovf"}, {7'd0, ifc.ovf}, {7'd0, eovf});
        @(posedge clk);
        #1;
        chk({tag, "_done_drop"}, {7'd0, ifc.done}, 8'd0);
        chk({tag, "_busy_drop"}, {7'd0, ifc.busy}, 8'd0);
        @(posedge clk);
        #1;
        chk({tag, "_hold_re"}, ifc.result_re, er);
        chk({tag, "_hold_im"}, ifc.result_im, ei);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        ifc.a      = 8'h00;
        ifc.b      = 8'h00;
        ifc.start  = 1'b0;
        rst_n      = 1'b1;
        #2 rst_n   = 1'b0;
        #20;
        chk("rst_busy", {7'd0, ifc.busy}, 8'd0);
        chk("rst_done", {7'd0, ifc.done}, 8'd0);
        chk("rst_re", ifc.result_re, 8'h00);
        chk("rst_im", ifc.result_im, 8'h00);
        chk("rst_dz", {7'd0, ifc.dz}, 8'd0);
        chk("rst_ovf", {7'd0, ifc.ovf}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_busy", {7'd0, ifc.busy}, 8'd0);

        run_op(8'h02, 8'h01, 8'h20, 8'h00, 1'b0, 1'b0, LATENCY, "two_by_one");
        run_op(8'h11, 8'h11, 8'h10, 8'h00, 1'b0, 1'b0, LATENCY, "same");
        run_op(8'h01, 8'h10, 8'h00, 8'hF0, 1'b0, 1'b0, LATENCY, "by_j");
        run_op(8'h07, 8'h03, 8'h25, 8'h00, 1'b0, 1'b0, LATENCY, "trunc_pos");
        run_op(8'h09, 8'h03, 8'hDB, 8'h00, 1'b0, 1'b0, LATENCY, "trunc_neg");
        run_op(8'h08, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0, LATENCY, "min_exact");
        run_op(8'h70, 8'h01, 8'h00, 8'h70, 1'b0, 1'b0, LATENCY, "imag_only");

        // Divide by zero, with start held through the busy and done cycles.
        @(negedge clk);
        ifc.a     = 8'h35;
        ifc.b     = 8'h00;
        ifc.start = 1'b1;
        @(posedge clk);
        #1;
        chk("dz_busy1", {7'd0, ifc.busy}, 8'd1);
        chk("dz_done1", {7'd0, ifc.done}, 8'd0);
        @(posedge clk);
        #1;
        chk("dz_done2", {7'd0, ifc.done}, 8'd1);
        chk("dz_flag", {7'd0, ifc.dz}, 8'd1);
        chk("dz_re", ifc.result_re, 8'h00);
        chk("dz_im", ifc.result_im, 8'h00);
        chk("dz_ovf", {7'd0, ifc.ovf}, 8'd0);
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        chk("dz_done3", {7'd0, ifc.done}, 8'd0);
        chk("dz_busy3", {7'd0, ifc.busy}, 8'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("dz_no_queue_busy", {7'd0, ifc.busy}, 8'd0);
        chk("dz_no_queue_done", {7'd0, ifc.done}, 8'd0);

        run_op(8'h08, 8'h0F, 8'h7F, 8'h00, 1'b0, 1'b1, LATENCY, "sat_pos");

        // Reset asserted while the imaginary part is being divided.
        @(negedge clk);
        ifc.a     = 8'h02;
        ifc.b     = 8'h01;
        ifc.start = 1'b1;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        repeat (17) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {7'd0, ifc.busy}, 8'd0);
        chk("mid_rst_done", {7'd0, ifc.done}, 8'd0);
        chk("mid_rst_re", ifc.result_re, 8'h00);
        chk("mid_rst_im", ifc.result_im, 8'h00);
        chk("mid_rst_dz", {7'd0, ifc.dz}, 8'd0);
        chk("mid_rst_ovf", {7'd0, ifc.ovf}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post_rst_idle", {7'd0, ifc.done}, 8'd0);

        run_op(8'h02, 8'h01, 8'h20, 8'h00, 1'b0, 1'b0, LATENCY, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
